// File: rtl/i2s_receiver.sv
// I2S bus-master receiver: generates SCLK/LRCLK from MCLK and captures
// left-justified stereo words into a valid/ready output stage.
module i2s_receiver #(
  parameter int BIT_DEPTH = 16,
  parameter int SAMP_RATE = 44100,
  parameter int S_PS      = 100000000 / (4 * SAMP_RATE * BIT_DEPTH)
) (
  input  logic                 MCLK,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 SD,
  output logic                 SCLK,
  output logic                 LRCLK,
  output logic [BIT_DEPTH-1:0] data_l,
  output logic [BIT_DEPTH-1:0] data_r,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun
);

  localparam int DIV_W = (S_PS > 1) ? $clog2(S_PS) : 1;
  localparam int CNT_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(S_PS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DEPTH - 1);

  logic [DIV_W-1:0]     div;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 sd_meta;
  logic                 sd_sync;
  logic [BIT_DEPTH-1:0] shift;
  logic [BIT_DEPTH-1:0] hold_l;
  logic                 have_left;
  logic                 lr_pending;

  logic                 tick;
  logic                 rise;
  logic                 fall;
  logic                 word_done;
  logic                 frame_done;
  logic [BIT_DEPTH-1:0] word;

  assign tick       = enable && (div == DIV_LAST);
  assign rise       = tick && !SCLK;
  assign fall       = tick && SCLK;
  assign word       = {shift[BIT_DEPTH-2:0], sd_sync};
  assign word_done  = rise && (bit_cnt == CNT_LAST);
  assign frame_done = word_done && !LRCLK && have_left;

  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= SD;
      sd_sync <= sd_meta;
    end
  end

  // Bus clocks, bit capture and left-word holding register.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      SCLK       <= 1'b0;
      LRCLK      <= 1'b1;
      bit_cnt    <= '0;
      shift      <= '0;
      hold_l     <= '0;
      have_left  <= 1'b0;
      lr_pending <= 1'b0;
    end else if (!enable) begin
      div        <= '0;
      SCLK       <= 1'b0;
      LRCLK      <= 1'b1;
      bit_cnt    <= '0;
      shift      <= '0;
      have_left  <= 1'b0;
      lr_pending <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) SCLK <= !SCLK;
      if (rise) begin
        shift   <= word;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) begin
        lr_pending <= 1'b1;
        if (LRCLK) begin
          hold_l    <= word;
          have_left <= 1'b1;
        end else begin
          have_left <= 1'b0;
        end
      end
      if (fall && lr_pending) begin
        LRCLK      <= !LRCLK;
        lr_pending <= 1'b0;
      end
    end
  end

  // The right word completes in the same cycle as the frame, so it is
  // taken straight from the shift path to keep the one-cycle latency.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data_l  <= '0;
      data_r  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!valid || ready) begin
          data_l <= hold_l;
          data_r <= word;
          valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: an I2S source model serializes frames,
// a monitor compares every handshaked frame against the expected queue.
`timescale 1ns/1ps
module tb_i2s_receiver;
  localparam int BD  = 16;
  localparam int SPS = 2;

  logic          MCLK = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          SD;
  logic          ready;
  logic          SCLK;
  logic          LRCLK;
  logic          valid;
  logic          overrun;
  logic [BD-1:0] data_l;
  logic [BD-1:0] data_r;

  i2s_receiver #(.BIT_DEPTH(BD), .S_PS(SPS)) dut (
    .MCLK(MCLK), .rst_n(rst_n), .enable(enable), .SD(SD),
    .SCLK(SCLK), .LRCLK(LRCLK), .data_l(data_l), .data_r(data_r),
    .valid(valid), .ready(ready), .overrun(overrun)
  );

  always #5 MCLK = ~MCLK;

  int vectors = 0;
  int miscompares = 0;
  bit bitq[$];
  logic [31:0] exp_q[$];

  // observation state, sampled on the falling MCLK edge
  int cyc = 0, rise_cnt = 0, last_rise = 0, sclk_period = 0;
  int last_lrf = 0, lr_period = 0, ovr_cnt = 0;
  int vr_cnt = 0, vr_with_rise = 0;
  logic prev_sclk = 1'b0, prev_lr = 1'b1, prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial forever begin
    @(negedge MCLK);
    cyc++;
    if (SCLK && !prev_sclk) begin
      rise_cnt++;
      sclk_period = cyc - last_rise;
      last_rise = cyc;
    end
    if (!LRCLK && prev_lr) begin
      lr_period = cyc - last_lrf;
      last_lrf = cyc;
    end
    if (valid && !prev_valid) begin
      vr_cnt = rise_cnt;
      vr_with_rise = (SCLK && !prev_sclk) ? 1 : 0;
    end
    if (overrun) ovr_cnt++;
    prev_sclk = SCLK;
    prev_lr = LRCLK;
    prev_valid = valid;
  end

  initial forever begin
    @(negedge MCLK);
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got %h%h, required no frame", data_l, data_r);
      end else begin
        check("frame", {data_l, data_r}, exp_q.pop_front());
      end
    end
  end

  // I2S source: next bit goes out a random delay after each SCLK rise,
  // settling well before the receiver samples it.
  initial forever begin
    @(posedge SCLK);
    #($urandom_range(1, 18));
    if (bitq.size() > 0) SD = bitq.pop_front();
    else SD = 1'b0;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic add_frame(input logic [BD-1:0] l, input logic [BD-1:0] r, input bit expect_it);
    for (int i = BD - 1; i >= 0; i--) bitq.push_back(l[i]);
    for (int i = BD - 1; i >= 0; i--) bitq.push_back(r[i]);
    if (expect_it) exp_q.push_back({l, r});
  endtask

  int rise_base = 0;

  task automatic start_session();
    SD = bitq.pop_front();
    repeat (3) @(posedge MCLK);
    #1;
    rise_base = rise_cnt;
    enable = 1'b1;
  endtask

  task automatic drain_and_stop(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge MCLK);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge MCLK);
    #1 enable = 1'b0;
    repeat (5) @(posedge MCLK);
    #1 bitq.delete();
  endtask

  initial begin
    int n;
    int ovr_base;
    logic [BD-1:0] l, r;
    rst_n = 1'b0; enable = 1'b1; ready = 1'b1; SD = 1'b0;

    // reset values with enable held high, and first-rise latency
    repeat (3) @(posedge MCLK);
    #1;
    check("rst_sclk", SCLK, 0);
    check("rst_lrclk", LRCLK, 1);
    check("rst_valid", valid, 0);
    check("rst_data", {data_l, data_r}, 0);
    check("rst_overrun", overrun, 0);
    @(negedge MCLK) rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && !SCLK; i++) begin
      @(posedge MCLK);
      #1 n++;
    end
    check("first_rise_latency", n, 2);
    enable = 1'b0;
    repeat (5) @(posedge MCLK);

    // single frame: latency relative to the 32nd rise, SCLK period
    add_frame(16'hA5C3, 16'h3C5A, 1);
    start_session();
    drain_and_stop("basic", 400);
    check("valid_at_rise_idx", vr_cnt - rise_base, 32);
    check("valid_with_rise", vr_with_rise, 1);
    check("sclk_period", sclk_period, 4);

    // overrun: second frame dropped while ready is low
    ready = 1'b0;
    ovr_base = ovr_cnt;
    add_frame(16'h1111, 16'h2222, 1);
    add_frame(16'h3333, 16'h4444, 0);
    start_session();
    for (int i = 0; i < 600 && ovr_cnt == ovr_base; i++) @(posedge MCLK);
    repeat (3) @(posedge MCLK);
    #1;
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    check("ovr_valid_held", valid, 1);
    check("ovr_data_held", {data_l, data_r}, 32'h1111_2222);
    ready = 1'b1;
    @(posedge MCLK);
    #1 check("ovr_valid_drop", valid, 0);
    drain_and_stop("ovr", 10);

    // disable mid right word: partial frame discarded
    add_frame(16'hDEAD, 16'hBEEF, 0);
    start_session();
    for (int i = 0; i < 400 && (rise_cnt - rise_base) < BD + 8; i++) @(negedge MCLK);
    check("partial_rises", rise_cnt - rise_base, BD + 8);
    @(posedge MCLK);
    #1 enable = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge MCLK);
      #1 if (SCLK !== 1'b0 || LRCLK !== 1'b1 || valid !== 1'b0) n++;
    end
    check("disabled_idle_errs", n, 0);
    bitq.delete();
    add_frame(16'h7FFF, 16'h8000, 1);
    start_session();
    drain_and_stop("reenable", 400);

    // asynchronous reset mid left word while a frame is pending
    ready = 1'b0;
    add_frame(16'h1234, 16'h5678, 0);
    add_frame(16'h9ABC, 16'hDEF0, 0);
    start_session();
    for (int i = 0; i < 400 && !valid; i++) begin
      @(posedge MCLK);
      #1;
    end
    check("pre_rst_frame", {valid, data_l, data_r}, {1'b1, 32'h1234_5678});
    repeat (20) @(posedge MCLK);
    #2 rst_n = 1'b0; enable = 1'b0;
    #1;
    check("async_rst_outputs", {SCLK, LRCLK, valid, overrun}, 4'b0100);
    check("async_rst_data", {data_l, data_r}, 0);
    @(negedge MCLK) rst_n = 1'b1;
    ready = 1'b1;
    repeat (40) @(posedge MCLK);
    #1 check("no_stale_valid", valid, 0);
    bitq.delete();
    add_frame(16'h0F0F, 16'hF0F0, 1);
    start_session();
    drain_and_stop("post_rst", 400);

    // randomized back-to-back frames with random SD change offsets
    for (int f = 0; f < 100; f++) begin
      l = BD'($urandom);
      r = BD'($urandom);
      add_frame(l, r, 1);
    end
    start_session();
    drain_and_stop("random", 100 * 128 + 400);
    check("lrclk_period", lr_period, 128);
    check("sclk_period_rand", sclk_period, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter BIT_DEPTH, default 16, bits per channel word.
REQ-002 Parameter SAMP_RATE, default 44100, stereo frame rate in Hz.
REQ-003 Parameter S_PS, default 100000000/(4*SAMP_RATE*BIT_DEPTH) (=35), MCLK cycles per SCLK half period; legal range 2 and up.
REQ-004 MCLK  input  1  100 MHz system clock; every register is clocked on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  1 = generate bus clocks and receive; 0 = idle.
REQ-007 SD  input  1  serial data from the external I2S source (mic/ADC); asynchronous to MCLK.
REQ-008 SCLK  output  1  bit clock, driven by this block as bus master.
REQ-009 LRCLK  output  1  word select; 1 = left slot, 0 = right slot.
REQ-010 data_l  output  BIT_DEPTH  left sample of the last accepted frame, two's complement, MSB first on the wire.
REQ-011 data_r  output  BIT_DEPTH  right sample of the same frame.
REQ-012 valid  output  1  data_l/data_r hold an unconsumed frame.
REQ-013 ready  input  1  consumer accepts the frame in a cycle with valid=1 and ready=1.
REQ-014 overrun  output  1  one-MCLK pulse when a completed frame is dropped.

Function
REQ-015 SCLK SHALL toggle every S_PS MCLK cycles while enable=1, giving a period of 2*S_PS cycles.
REQ-016 "Rise event" and "fall event" SHALL mean the MCLK cycle in which the SCLK register toggles 0->1 or 1->0.
REQ-017 SD SHALL pass through a 2-flop synchronizer; the synchronized value is sampled only on rise events.
REQ-018 The format is left-justified: the MSB is sampled on the first rise event after an LRCLK transition, and LSB follows after BIT_DEPTH-1 further rises.
REQ-019 A bit counter 0..BIT_DEPTH-1 SHALL advance on each rise event and wrap to 0 after BIT_DEPTH-1.
REQ-020 The incoming bit SHALL be shifted into a BIT_DEPTH shift register (left shift, new bit at LSB).
REQ-021 At the rise event with count BIT_DEPTH-1, the completed word SHALL be written to the left holding register if LRCLK=1, else to the right holding register.
REQ-022 LRCLK SHALL toggle on the first fall event following a word completion, so each slot lasts exactly BIT_DEPTH SCLK periods.
REQ-023 A frame is complete when a right word completes and the left word of the same frame was captured in this enable session; a right word with no preceding left word SHALL be discarded.
REQ-024 On frame completion with valid=0, or with valid=1 and ready=1 in the same cycle, data_l/data_r SHALL load the holding registers and valid SHALL be 1 in the next MCLK cycle (latency 1 cycle after the final rise event).
REQ-025 On frame completion with valid=1 and ready=0, the outputs SHALL stay unchanged, the new frame SHALL be dropped, and overrun SHALL pulse high for 1 cycle.
REQ-026 valid SHALL clear in the cycle after valid=1 and ready=1 unless REQ-024 reloads it.
REQ-027 enable=0 SHALL set SCLK=0 and LRCLK=1, zero the divider, bit counter and shift register, and discard any partial frame; valid, data_l and data_r SHALL be held.
REQ-028 On enable 0->1, the first SCLK rise SHALL occur S_PS cycles later and the first slot is left.

Reset
REQ-029 rst_n=0 SHALL immediately set SCLK=0, LRCLK=1, valid=0, overrun=0, data_l=0, data_r=0, and clear all counters, the synchronizer, the shift register and the holding registers, including mid-word.
REQ-030 After rst_n deasserts, operation SHALL resume per REQ-028 if enable=1.

Verification (S_PS=2, BIT_DEPTH=16)
REQ-031 Reset with enable=1 -> SCLK=0, LRCLK=1, valid=0, data_l=data_r=0; the first rise comes 2 cycles after reset release.
REQ-032 Serve left 16'hA5C3 and right 16'h3C5A, ready=1 -> valid=1 with data_l=A5C3 and data_r=3C5A exactly 1 cycle after the 32nd rise event; SCLK period 4 MCLK; LRCLK period 128 MCLK.
REQ-033 Hold ready=0 across frames 16'h1111/2222 then 3333/4444 -> outputs stay 1111/2222, overrun pulses once, valid stays 1; with ready=1 -> valid drops next cycle.
REQ-034 Drop enable after 8 right-slot bits, then re-enable and serve 7FFF/8000 -> no valid for the partial frame; the next valid carries 7FFF/8000; SCLK stays 0 and LRCLK stays 1 while disabled.
REQ-035 Assert rst_n=0 mid-left-word with valid=1 -> all outputs are at reset values in the same cycle, and no stale frame appears after release.
REQ-036 SD toggling at random offsets relative to MCLK, with back-to-back frames -> every captured word matches the serialized value, with no slip across 100 frames.
